// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding between decode and the ALU stage.
// A shift-register scoreboard of in-flight writers drives forwarding, load-use stalls and jump squashes.
module hazard_forward_unit #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int FWD_DEPTH  = 3,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        id_valid,
   input  logic [REG_ADDR_W-1:0]       id_src1,
   input  logic [REG_ADDR_W-1:0]       id_src2,
   input  logic                        id_src1_used,
   input  logic                        id_src2_used,
   input  logic [REG_ADDR_W-1:0]       id_dest,
   input  logic                        id_wb,
   input  logic                        id_mem_read,
   input  logic                        jump_occured,
   input  logic [DATA_W-1:0]           rf_data1,
   input  logic [DATA_W-1:0]           rf_data2,
   input  logic [FWD_DEPTH*DATA_W-1:0] stage_data,
   output logic [DATA_W-1:0]           op1,
   output logic [DATA_W-1:0]           op2,
   output logic [SEL_W-1:0]            fwd_sel1,
   output logic [SEL_W-1:0]            fwd_sel2,
   output logic                        stall,
   output logic                        flush,
   output logic [CNT_W-1:0]            stall_count,
   output logic [CNT_W-1:0]            flush_count
);

   logic [FWD_DEPTH-1:0]                 ent_valid_q, ent_valid_d;
   logic [FWD_DEPTH-1:0]                 ent_wb_q, ent_wb_d;
   logic [FWD_DEPTH-1:0]                 ent_mr_q, ent_mr_d;
   logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0] ent_dest_q, ent_dest_d;
   logic [CNT_W-1:0]                     stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]                     flush_cnt_q, flush_cnt_d;

   logic [FWD_DEPTH-1:0] hit1, hit2;
   logic                 lu1, lu2;
   logic                 issue;

   genvar gi;
   generate
      for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_match
         assign hit1[gi] = ent_valid_q[gi] && ent_wb_q[gi] && (ent_dest_q[gi] == id_src1);
         assign hit2[gi] = ent_valid_q[gi] && ent_wb_q[gi] && (ent_dest_q[gi] == id_src2);
      end
   endgenerate

   // Scan oldest to youngest so the youngest matching entry overwrites the selection.
   always_comb begin
      fwd_sel1 = '0;
      fwd_sel2 = '0;
      op1      = rf_data1;
      op2      = rf_data2;
      lu1      = 1'b0;
      lu2      = 1'b0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         if (id_src1_used && hit1[k]) begin
            fwd_sel1 = SEL_W'(k + 1);
            op1      = stage_data[k*DATA_W +: DATA_W];
            lu1      = ent_mr_q[k] && (k < LOAD_LAT);
         end
         if (id_src2_used && hit2[k]) begin
            fwd_sel2 = SEL_W'(k + 1);
            op2      = stage_data[k*DATA_W +: DATA_W];
            lu2      = ent_mr_q[k] && (k < LOAD_LAT);
         end
      end
   end

   assign flush = jump_occured;
   assign stall = (lu1 || lu2) && id_valid && !jump_occured;
   assign issue = id_valid && !stall && !flush;

   always_comb begin
      ent_valid_d = {ent_valid_q[FWD_DEPTH-2:0], issue};
      ent_wb_d    = {ent_wb_q[FWD_DEPTH-2:0], id_wb && issue};
      ent_mr_d    = {ent_mr_q[FWD_DEPTH-2:0], id_mem_read && issue};
      ent_dest_d  = {ent_dest_q[FWD_DEPTH-2:0], id_dest};
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_valid_q <= '0;
         ent_wb_q    <= '0;
         ent_mr_q    <= '0;
         ent_dest_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ent_valid_q <= ent_valid_d;
         ent_wb_q    <= ent_wb_d;
         ent_mr_q    <= ent_mr_d;
         ent_dest_q  <= ent_dest_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule
